mem_access_stage: RTL and testbench

//  MEM stage of the pipeline CPU. Sits between the EX/MEM register and the MEM/WB register, and produces MEM_res for the MEM/WB register.

---
 rtl/mem_access_stage_pkg.sv | 52 +++++
 rtl/load_extend.sv | 29 ++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: memory opcodes, FSM states and the
// decoded access descriptor used by the top and by load_extend.
package mem_access_stage_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef struct packed {
      logic  is_mem;
      logic  is_store;
      size_e size;
   } mem_op_t;

   function automatic mem_op_t decode_op(input logic [5:0] opcode);
      mem_op_t d;
      d = '{is_mem: 1'b0, is_store: 1'b0, size: SZ_WORD};
      case (opcode)
         OP_LW:         d = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_WORD};
         OP_LB, OP_LBU: d = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_BYTE};
         OP_LH, OP_LHU: d = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_HALF};
         OP_SW:         d = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_WORD};
         OP_SB:         d = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_BYTE};
         OP_SH:         d = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_HALF};
         default:       d = '{is_mem: 1'b0, is_store: 1'b0, size: SZ_WORD};
      endcase
      return d;
   endfunction

   // Bytes never misalign; halves need a[0]==0, words need a[1:0]==0.
   function automatic logic is_misaligned(input mem_op_t d, input logic [1:0] a);
      return ((d.size == SZ_HALF) && a[0]) || ((d.size == SZ_WORD) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a 32-bit read word and sign- or
// zero-extends it according to the load opcode. Purely combinational.
module load_extend
   import mem_access_stage_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      result    = rdata;
      byte_lane = rdata[{addr_lo, 3'b000} +: 8];
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (opcode)
         OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
         OP_LBU:  result = {24'h0, byte_lane};
         OP_LH:   result = {{16{half_lane[15]}}, half_lane};
         OP_LHU:  result = {16'h0, half_lane};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: ALU pass-through plus a req/ack data-memory FSM with
// timeout. Optional misalignment trapping is enabled by defining MEM_ALIGN_CHK_EN.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DADDR_W        = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk_i,
   input  logic               rst_n,
   input  logic [31:0]        instr_i,
   input  logic [31:0]        alu_res_i,
   input  logic [31:0]        rt_data_i,
   input  logic               RegWrite_i,
   output logic [31:0]        MEM_res_o,
   output logic               RegWrite_o,
   output logic               stall_o,
   output logic               dmem_req_o,
   output logic               dmem_we_o,
   output logic [DADDR_W-1:0] dmem_addr_o,
   output logic [3:0]         dmem_be_o,
   output logic [31:0]        dmem_wdata_o,
   input  logic [31:0]        dmem_rdata_i,
   input  logic               dmem_ack_i,
   output logic               bus_err_o,
   output logic               align_err_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      rdata_q;
   logic             bus_err_q;
   logic             align_err_q;
   mem_op_t          op;
   logic             misaligned;
   logic             timeout;
   logic [31:0]      load_res;
   logic [3:0]       be_w;
   logic [31:0]      wdata_w;
   logic             unused_instr;

   assign op           = decode_op(instr_i[31:26]);
   assign timeout      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign unused_instr = ^instr_i[25:0];

`ifdef MEM_ALIGN_CHK_EN
   assign misaligned = op.is_mem & is_misaligned(op, alu_res_i[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   load_extend u_load_extend (
      .opcode  (instr_i[31:26]),
      .addr_lo (alu_res_i[1:0]),
      .rdata   (rdata_q),
      .result  (load_res)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (op.is_mem) state_d = misaligned ? DONE : REQ;
         REQ:     if (dmem_ack_i || timeout) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: rdata_q is an ordinary flop and is reset with the FSM; only real RAM arrays may skip reset.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rdata_q     <= '0;
         bus_err_q   <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               cnt_q       <= '0;
               bus_err_q   <= 1'b0;
               align_err_q <= misaligned;
            end
            REQ: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (dmem_ack_i)   rdata_q   <= dmem_rdata_i;
               else if (timeout) bus_err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Store lanes: data replicated across the word, enables pick the addressed lane.
   always_comb begin
      be_w    = 4'b1111;
      wdata_w = rt_data_i;
      case (op.size)
         SZ_BYTE: begin
            be_w    = 4'b0001 << alu_res_i[1:0];
            wdata_w = {4{rt_data_i[7:0]}};
         end
         SZ_HALF: begin
            be_w    = alu_res_i[1] ? 4'b1100 : 4'b0011;
            wdata_w = {2{rt_data_i[15:0]}};
         end
         default: ;
      endcase
      if (!op.is_store) be_w = 4'b1111;
   end

   always_comb begin
      MEM_res_o    = alu_res_i;
      RegWrite_o   = 1'b0;
      stall_o      = 1'b0;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_be_o    = '0;
      dmem_wdata_o = '0;
      bus_err_o    = 1'b0;
      align_err_o  = 1'b0;
      case (state_q)
         IDLE: begin
            stall_o    = op.is_mem;
            RegWrite_o = RegWrite_i & ~op.is_mem;
         end
         REQ: begin
            stall_o      = 1'b1;
            dmem_req_o   = 1'b1;
            dmem_we_o    = op.is_store;
            dmem_addr_o  = {alu_res_i[DADDR_W-1:2], 2'b00};
            dmem_be_o    = be_w;
            dmem_wdata_o = op.is_store ? wdata_w : 32'h0;
         end
         DONE: begin
            MEM_res_o   = op.is_store ? alu_res_i : load_res;
            RegWrite_o  = RegWrite_i & ~(bus_err_q | align_err_q);
            bus_err_o   = bus_err_q;
            align_err_o = align_err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized bench for mem_access_stage against a byte-level
// reference model of loads, stores, lane enables and timeouts.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   localparam int TIMEOUT = 16;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic [31:0] instr_i, alu_res_i, rt_data_i;
   logic        RegWrite_i;
   logic [31:0] MEM_res_o;
   logic        RegWrite_o, stall_o, dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o, dmem_rdata_i;
   logic        dmem_ack_i, bus_err_o, align_err_o;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   mem_access_stage #(.DADDR_W(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .instr_i      (instr_i),
      .alu_res_i    (alu_res_i),
      .rt_data_i    (rt_data_i),
      .RegWrite_i   (RegWrite_i),
      .MEM_res_o    (MEM_res_o),
      .RegWrite_o   (RegWrite_o),
      .stall_o      (stall_o),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_be_o    (dmem_be_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_rdata_i (dmem_rdata_i),
      .dmem_ack_i   (dmem_ack_i),
      .bus_err_o    (bus_err_o),
      .align_err_o  (align_err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: access size in bytes, lane base, masks and extension by arithmetic.
   function automatic int unsigned op_bytes(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         default:              return 4;
      endcase
   endfunction

   function automatic bit op_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
   endfunction

   function automatic bit op_signed(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

   function automatic int unsigned lane_base(input logic [5:0] op, input logic [31:0] addr);
      int unsigned n;
      n = op_bytes(op);
      return (addr % 4) - ((addr % 4) % n);
   endfunction

   function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] addr);
      int unsigned mask;
      if (!op_store(op)) return 4'hF;
      mask = ((1 << op_bytes(op)) - 1) << lane_base(op, addr);
      return mask[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] rt);
      logic [31:0] w;
      int unsigned n;
      n = op_bytes(op);
      for (int k = 0; k < 4; k++) w[8*k +: 8] = rt[8*(k % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      longint v;
      int unsigned bits;
      bits = 8 * op_bytes(op);
      v = longint'({32'h0, rdata}) >> (8 * lane_base(op, addr));
      v = v & ((64'd1 << bits) - 1);
      if (op_signed(op) && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
      return v[31:0];
   endfunction

   task automatic run_mem(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input int unsigned waits, input logic rw,
                          input logic stray_ack);
      logic [31:0] exp_res;
      exp_res = op_store(op) ? addr : model_load(op, addr, rdata);
      @(negedge clk_i);
      instr_i      = {op, 26'h155};
      alu_res_i    = addr;
      rt_data_i    = rt;
      RegWrite_i   = rw;
      dmem_ack_i   = stray_ack;
      dmem_rdata_i = ~rdata;
      #1;
      check("idle_stall", stall_o, 1);
      check("idle_req", dmem_req_o, 0);
      check("idle_regwrite", RegWrite_o, 0);
      for (int i = 1; i <= int'(waits); i++) begin
         @(negedge clk_i);
         dmem_ack_i   = (i == int'(waits));
         dmem_rdata_i = (i == int'(waits)) ? rdata : $urandom();
         #1;
         check("req_req", dmem_req_o, 1);
         check("req_stall", stall_o, 1);
         check("req_we", dmem_we_o, op_store(op));
         check("req_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
         check("req_be", dmem_be_o, model_be(op, addr));
         if (op_store(op)) check("req_wdata", dmem_wdata_o, model_wdata(op, rt));
         check("req_regwrite", RegWrite_o, 0);
      end
      @(negedge clk_i);
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = $urandom();
      #1;
      check("done_stall", stall_o, 0);
      check("done_req", dmem_req_o, 0);
      check("done_res", MEM_res_o, exp_res);
      check("done_regwrite", RegWrite_o, rw);
      check("done_bus_err", bus_err_o, 0);
   endtask

   logic [5:0] ops [8];

   initial begin
      logic [5:0]  rop;
      logic [31:0] raddr;
      ops = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH};

      rst_n = 1'b0; instr_i = '0; alu_res_i = '0; rt_data_i = '0; RegWrite_i = 1'b0;
      dmem_rdata_i = '0; dmem_ack_i = 1'b0;
      repeat (2) @(negedge clk_i);
      #1;
      check("rst_stall", stall_o, 0);
      check("rst_req", dmem_req_o, 0);
      check("rst_res", MEM_res_o, 0);
      check("rst_regwrite", RegWrite_o, 0);
      check("rst_bus_err", bus_err_o, 0);
      check("rst_align_err", align_err_o, 0);
      @(negedge clk_i);
      rst_n = 1'b1;

      // Non-memory op passes straight through in the same cycle.
      @(negedge clk_i);
      instr_i = 32'h0000_0020; alu_res_i = 32'h0000_1234; RegWrite_i = 1'b1;
      #1;
      check("add_res", MEM_res_o, 32'h0000_1234);
      check("add_stall", stall_o, 0);
      check("add_req", dmem_req_o, 0);
      check("add_regwrite", RegWrite_o, 1);

      run_mem(OP_LW,  32'h10, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 1'b0);
      run_mem(OP_LB,  32'h13, 32'h0, 32'h8000_0000, 2, 1'b1, 1'b0);
      run_mem(OP_LBU, 32'h13, 32'h0, 32'h8000_0000, 1, 1'b1, 1'b1);
      run_mem(OP_LH,  32'h12, 32'h0, 32'h8000_0000, 3, 1'b1, 1'b0);
      run_mem(OP_SB,  32'h05, 32'h0000_00AB, 32'h0, 1, 1'b0, 1'b0);

      // Timeout: no ack for the whole window.
      @(negedge clk_i);
      instr_i = {OP_LW, 26'h0}; alu_res_i = 32'h20; RegWrite_i = 1'b1; dmem_ack_i = 1'b0;
      repeat (TIMEOUT) begin
         @(negedge clk_i);
         #1;
         check("to_req", dmem_req_o, 1);
      end
      @(negedge clk_i);
      #1;
      check("to_bus_err", bus_err_o, 1);
      check("to_regwrite", RegWrite_o, 0);
      check("to_stall", stall_o, 0);
      check("to_req_done", dmem_req_o, 0);
      @(negedge clk_i);
      instr_i = 32'h0;
      #1;
      check("to_bus_err_pulse", bus_err_o, 0);
      check("to_idle_stall", stall_o, 0);

      // Reset asserted mid-REQ drops the request without a clock edge.
      @(negedge clk_i);
      instr_i = {OP_LW, 26'h0}; alu_res_i = 32'h40;
      @(negedge clk_i);
      #1;
      check("mid_req_up", dmem_req_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", dmem_req_o, 0);
      @(negedge clk_i);
      instr_i = 32'h0; rst_n = 1'b1;
      #1;
      check("mid_rst_stall", stall_o, 0);
      check("mid_rst_req2", dmem_req_o, 0);

`ifdef MEM_ALIGN_CHK_EN
      @(negedge clk_i);
      instr_i = {OP_LW, 26'h0}; alu_res_i = 32'h02; RegWrite_i = 1'b1;
      #1;
      check("mis_idle_stall", stall_o, 1);
      @(negedge clk_i);
      #1;
      check("mis_req", dmem_req_o, 0);
      check("mis_align_err", align_err_o, 1);
      check("mis_regwrite", RegWrite_o, 0);
      @(negedge clk_i);
      instr_i = 32'h0;
      #1;
      check("mis_align_pulse", align_err_o, 0);
`else
      run_mem(OP_LW, 32'h02, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 1'b0);
      check("noalign_err", align_err_o, 0);
`endif

      // Randomized back-to-back traffic.
      for (int t = 0; t < 60; t++) begin
         rop   = ops[$urandom_range(0, 7)];
         raddr = $urandom();
`ifdef MEM_ALIGN_CHK_EN
         raddr = raddr & ~(op_bytes(rop) - 1);
`endif
         run_mem(rop, raddr, $urandom(), $urandom(), $urandom_range(1, 4),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
